register: RTL and testbench

- Parameterised WIDTH-bit storage register with synchronous load enable and synchronous active-high reset.
- General-purpose holding register for datapaths: captures data_in on a clock edge when load is asserted and holds it otherwise.
- Single clock domain, no handshake; data_out is driven directly from the storage flops.

---
 rtl/register.sv | 32 +++
 tb/tb_register.sv | 103 ++++++++++
 2 files changed

// File: rtl/register.sv
// WIDTH-bit holding register: synchronous active-high reset has priority over load.
// data_out comes straight from the storage flops.
module register #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (rst) begin
      data_d = RESET_VALUE;
    end else if (load) begin
      data_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_register.sv
// Directed and random checks of register at WIDTH=8, 1 and 32, plus a non-zero reset value.
module tb_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  d8 = '0;
  logic        d1 = 1'b0;
  logic [31:0] d32 = '0;
  logic [7:0]  o8, or8;
  logic        o1;
  logic [31:0] o32;

  logic [7:0]  m8, mr8;
  logic        m1;
  logic [31:0] m32;

  int total = 0;
  int fails = 0;

  localparam logic [7:0] ALT_RV = 8'hA5;

  always #5 clk = ~clk;

  register #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .load(load), .data_in(d8), .data_out(o8)
  );
  register #(.WIDTH(8), .RESET_VALUE(ALT_RV)) ur8 (
    .clk(clk), .rst(rst), .load(load), .data_in(d8), .data_out(or8)
  );
  register #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .data_in(d1), .data_out(o1)
  );
  register #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .load(load), .data_in(d32), .data_out(o32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, advance the reference, then compare 1ns later.
  task automatic cycle(input string tag, input logic r, input logic l,
                       input logic [7:0] v8, input logic v1, input logic [31:0] v32);
    rst  = r;
    load = l;
    d8   = v8;
    d1   = v1;
    d32  = v32;
    @(posedge clk);
    if (r) begin
      m8 = 8'h00; mr8 = ALT_RV; m1 = 1'b0; m32 = 32'h0;
    end else if (l) begin
      m8 = v8; mr8 = v8; m1 = v1; m32 = v32;
    end
    #1;
    chk({tag, "/w8"},  32'(o8),  32'(m8));
    chk({tag, "/rv8"}, 32'(or8), 32'(mr8));
    chk({tag, "/w1"},  32'(o1),  32'(m1));
    chk({tag, "/w32"}, o32, m32);
  endtask

  initial begin
    m8 = 'x; mr8 = 'x; m1 = 1'bx; m32 = 'x;
    @(negedge clk);

    // First-edge load with no prior reset.
    cycle("first_load", 1'b0, 1'b1, 8'h55, 1'b1, 32'hFFFF_FFFF);
    cycle("load_aa",    1'b0, 1'b1, 8'hAA, 1'b0, 32'hAAAA_AAAA);
    cycle("load_ff",    1'b0, 1'b1, 8'hFF, 1'b1, 32'h5555_5555);
    cycle("rst_over_load", 1'b1, 1'b1, 8'hFF, 1'b1, 32'hFFFF_FFFF);
    cycle("load_after_rst", 1'b0, 1'b1, 8'h3C, 1'b1, 32'h1234_5678);
    for (int unsigned i = 0; i < 3; i++)
      cycle("hold", 1'b0, 1'b0, (i % 2 == 0) ? 8'hC3 : 8'h3C, 1'(i), 32'(i) ^ 32'hDEAD_BEEF);

    cycle("load_5a", 1'b0, 1'b1, 8'h5A, 1'b0, 32'h0F0F_0F0F);
    // Reset pulse entirely between edges must not affect the stored value.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cycle("mid_rst_pulse", 1'b0, 1'b0, 8'h00, 1'b1, 32'h0);
    cycle("rst_held",  1'b1, 1'b0, 8'h00, 1'b1, 32'hFFFF_FFFF);
    cycle("load_81",   1'b0, 1'b1, 8'h81, 1'b1, 32'h8000_0001);

    for (int unsigned i = 0; i < 60; i++)
      cycle("random", $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom), $urandom);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
